// File: rtl/efuse_shadow_pkg.sv
// Shared types and constants for the efuse shadow loader.
package efuse_shadow_pkg;

  localparam int        SHADOW_W = 256;
  localparam int        NBYTE    = 32;
  localparam logic [7:0] CHK_KEY = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_VALID,
    ST_ERROR
  } state_e;

  // Byte 31 value a well-formed image must carry: (sum of bytes 0..30) ^ CHK_KEY.
  function automatic logic [7:0] f_chk_ref(input logic [SHADOW_W-1:0] d);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NBYTE - 1; i++) s = s + d[i*8 +: 8];
    return s ^ CHK_KEY;
  endfunction

endpackage

// File: rtl/efuse_shadow_if.sv
// Autoload chunk bus and shadow result bus. EFUSE_SHADOW_OVR_EN adds the register override port.
interface efuse_shadow_if #(parameter int NR = 64);
  localparam int NCH = 256 / NR;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic          load_start;
  logic          chunk_vld;
  logic [CW-1:0] chunk_sel;
  logic [NR-1:0] chunk_data;
  logic          load_done;
  logic [255:0]  shadow_data;
  logic          shadow_vld;
  logic          shadow_crc_err;
  logic          shadow_miss_err;
  logic          shadow_busy;
`ifdef EFUSE_SHADOW_OVR_EN
  logic          rg_shadow_ovr_we;
  logic [4:0]    rg_shadow_ovr_addr;
  logic [7:0]    rg_shadow_ovr_byte;
  logic          shadow_ovr;

  modport master (output load_start, chunk_vld, chunk_sel, chunk_data, load_done,
                  output rg_shadow_ovr_we, rg_shadow_ovr_addr, rg_shadow_ovr_byte,
                  input  shadow_data, shadow_vld, shadow_crc_err, shadow_miss_err,
                  input  shadow_busy, shadow_ovr);
  modport slave  (input  load_start, chunk_vld, chunk_sel, chunk_data, load_done,
                  input  rg_shadow_ovr_we, rg_shadow_ovr_addr, rg_shadow_ovr_byte,
                  output shadow_data, shadow_vld, shadow_crc_err, shadow_miss_err,
                  output shadow_busy, shadow_ovr);
`else
  modport master (output load_start, chunk_vld, chunk_sel, chunk_data, load_done,
                  input  shadow_data, shadow_vld, shadow_crc_err, shadow_miss_err,
                  input  shadow_busy);
  modport slave  (input  load_start, chunk_vld, chunk_sel, chunk_data, load_done,
                  output shadow_data, shadow_vld, shadow_crc_err, shadow_miss_err,
                  output shadow_busy);
`endif
endinterface

// File: rtl/efuse_shadow_chk.sv
// Sequential byte checksum: sums bytes 0..30 one per cycle, then compares byte 31 against sum ^ key.
module efuse_shadow_chk
  import efuse_shadow_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                clr_i,
  input  logic [SHADOW_W-1:0] data_i,
  output logic                done_o,
  output logic                pass_o
);

  logic       active_q, active_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] acc_q, acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (clr_i || start_i) begin
      active_d = start_i && !clr_i;
      idx_d    = '0;
      acc_d    = '0;
    end else if (active_q) begin
      if (idx_q == 5'(NBYTE - 1)) begin
        active_d = 1'b0;
      end else begin
        acc_d = acc_q + data_i[{idx_q, 3'b000} +: 8];
        idx_d = idx_q + 5'd1;
      end
    end
  end

  // Compare cycle: index has reached the key byte, acc holds sum of bytes 0..30.
  assign done_o = active_q && (idx_q == 5'(NBYTE - 1));
  assign pass_o = data_i[SHADOW_W-1 -: 8] == (acc_q ^ CHK_KEY);

endmodule

// File: rtl/efuse_shadow_load.sv
// Efuse autoload shadow register with chunk-presence and checksum validation.
// Optional byte override port enabled by EFUSE_SHADOW_OVR_EN.
module efuse_shadow_load
  import efuse_shadow_pkg::*;
#(
  parameter int NR = 64
) (
  input  logic           clk,
  input  logic           rst,
  efuse_shadow_if.slave  bus
);

  localparam int NCH = SHADOW_W / NR;

  state_e              state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q;
  logic [NCH-1:0]      bmp_q, bmp_nxt, sel_oh;
  logic                vld_q, crc_q, miss_q;
  logic                in_load, all_in, chk_start, chk_done, chk_pass;

  assign in_load   = (state_q == ST_LOAD);
  assign sel_oh    = NCH'(1) << bus.chunk_sel;
  // Presence including a chunk landing in the same cycle as load_done.
  assign bmp_nxt   = bmp_q | ((in_load && bus.chunk_vld) ? sel_oh : '0);
  assign all_in    = &bmp_nxt;
  assign chk_start = in_load && bus.load_done && all_in && !bus.load_start;

  efuse_shadow_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .start_i (chk_start),
    .clr_i   (bus.load_start),
    .data_i  (shadow_q),
    .done_o  (chk_done),
    .pass_o  (chk_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.load_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (bus.load_done) state_d = all_in ? ST_CHECK : ST_ERROR;
        ST_CHECK: if (chk_done)      state_d = chk_pass ? ST_VALID : ST_ERROR;
        default:  state_d = state_q;
      endcase
    end
  end

`ifdef EFUSE_SHADOW_OVR_EN
  logic ovr_q;
  logic ovr_ok;
  assign ovr_ok = bus.rg_shadow_ovr_we && (state_q == ST_VALID || state_q == ST_ERROR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      bmp_q    <= '0;
      vld_q    <= 1'b0;
      crc_q    <= 1'b0;
      miss_q   <= 1'b0;
`ifdef EFUSE_SHADOW_OVR_EN
      ovr_q    <= 1'b0;
`endif
    end else if (bus.load_start) begin
      shadow_q <= '0;
      bmp_q    <= '0;
      vld_q    <= 1'b0;
      crc_q    <= 1'b0;
      miss_q   <= 1'b0;
`ifdef EFUSE_SHADOW_OVR_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      if (in_load && bus.chunk_vld) begin
        shadow_q[bus.chunk_sel*NR +: NR] <= bus.chunk_data;
        bmp_q                            <= bmp_nxt;
      end
      if (in_load && bus.load_done && !all_in) miss_q <= 1'b1;
      if (state_q == ST_CHECK && chk_done) begin
        vld_q <= chk_pass;
        crc_q <= !chk_pass;
      end
`ifdef EFUSE_SHADOW_OVR_EN
      // Override patches the published image only; flags keep their checked verdict.
      if (ovr_ok) begin
        shadow_q[{bus.rg_shadow_ovr_addr, 3'b000} +: 8] <= bus.rg_shadow_ovr_byte;
        ovr_q                                           <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    bus.shadow_data     = shadow_q;
    bus.shadow_vld      = vld_q;
    bus.shadow_crc_err  = crc_q;
    bus.shadow_miss_err = miss_q;
    bus.shadow_busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`ifdef EFUSE_SHADOW_OVR_EN
    bus.shadow_ovr      = ovr_q;
`endif
  end

endmodule
